// File: rtl/fcpu_pkg.sv
// Shared CPU widths, opcode encodings and the memory-port state type.
package fcpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RSV_ID_W = 5;
  localparam int unsigned INSTR_W  = 6;
  localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_LOAD   = 6'h08;
  localparam logic [INSTR_W-1:0] I_LOADB  = 6'h09;
  localparam logic [INSTR_W-1:0] I_STORE  = 6'h0A;
  localparam logic [INSTR_W-1:0] I_STOREB = 6'h0B;
  localparam logic [INSTR_W-1:0] I_STORER = 6'h0C;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h0D;

  typedef enum logic {
    DMP_IDLE,
    DMP_LOAD_RESP
  } dmp_state_t;

  function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
    return (op == I_LOAD) || (op == I_LOADB);
  endfunction

  function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
    return (op == I_STORE) || (op == I_STOREB) || (op == I_STORER);
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// Single-port word RAM with per-byte write enables and a registered read
// port that holds its last value while re_i is low.
module byte_enable_ram
  import fcpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                re_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_port.sv
// Memory-side backend of the memory unit: RAM access, load result on the
// CDB, and a one-byte output stream register.
module data_memory_port
  import fcpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                i_valid,
  input  logic [INSTR_W-1:0]  i_opcode,
  input  logic [RSV_ID_W-1:0] i_rsv_id,
  input  logic [DATA_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic                i_ready,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready
);

  localparam int unsigned NB = DATA_W / 8;

  dmp_state_t          state_q, state_d;
  logic [RSV_ID_W-1:0] rsv_q, rsv_d;
  logic                byte_q, byte_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;

  logic                accept;
  logic                ram_re;
  logic [NB-1:0]       ram_we;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   load_data;
  logic                unused_addr;

  // Upper address bits are dropped so the address space wraps.
  assign unused_addr = ^i_address[DATA_W-1:ADDR_W];

  always_comb begin
    i_ready = (state_q == DMP_IDLE) && !clear;
    if ((i_opcode == I_OUTPUT) && out_valid_q && !out_ready) i_ready = 1'b0;
  end

  assign accept = i_valid & i_ready;
  assign ram_re = accept & is_load_op(i_opcode);
  assign ram_we = (accept && is_store_op(i_opcode))
                ? ((i_opcode == I_STOREB) ? NB'(1) : '1)
                : '0;

  byte_enable_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .addr_i  (i_address[ADDR_W-1:0]),
    .wdata_i (i_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DMP_IDLE;
      rsv_q       <= '0;
      byte_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsv_q       <= rsv_d;
      byte_q      <= byte_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rsv_d   = rsv_q;
    byte_d  = byte_q;
    unique case (state_q)
      DMP_IDLE: begin
        if (ram_re) begin
          state_d = DMP_LOAD_RESP;
          rsv_d   = i_rsv_id;
          byte_d  = (i_opcode == I_LOADB);
        end
      end
      DMP_LOAD_RESP: begin
        if (o_cdb_ready) state_d = DMP_IDLE;
      end
    endcase
    if (clear) state_d = DMP_IDLE;
  end

  // Drain and refill may coincide; the new byte wins.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept && (i_opcode == I_OUTPUT)) begin
      out_valid_d = 1'b1;
      out_data_d  = i_data[7:0];
    end
  end

  always_comb begin
    load_data   = byte_q ? {{(DATA_W-8){1'b0}}, ram_rdata[7:0]} : ram_rdata;
    o_cdb_valid = (state_q == DMP_LOAD_RESP);
    o_cdb       = o_cdb_valid ? {rsv_q, load_data} : '0;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_data_memory_port.sv
// Self-checking bench for data_memory_port: directed vectors, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_data_memory_port;
  import fcpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst, clear, i_valid, i_ready;
  logic [INSTR_W-1:0]  i_opcode;
  logic [RSV_ID_W-1:0] i_rsv_id;
  logic [DATA_W-1:0]   i_address, i_data;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid, o_cdb_ready;
  logic                out_valid, out_ready;
  logic [7:0]          out_data;

  always #5 clk = ~clk;

  data_memory_port #(
    .ADDR_W    (12),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .i_valid     (i_valid),
    .i_opcode    (i_opcode),
    .i_rsv_id    (i_rsv_id),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .o_cdb       (o_cdb),
    .o_cdb_valid (o_cdb_valid),
    .o_cdb_ready (o_cdb_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [7:0] got[$];

  always @(posedge clk) begin
    if (o_cdb_valid && o_cdb_ready) xfers++;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CDB_W-1:0] cdbv(input logic [RSV_ID_W-1:0] r, input logic [DATA_W-1:0] d);
    return {r, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [INSTR_W-1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [RSV_ID_W-1:0] r);
    i_valid   = 1'b1;
    i_opcode  = op;
    i_address = a;
    i_data    = d;
    i_rsv_id  = r;
  endtask

  typedef struct {
    logic [INSTR_W-1:0]  op;
    logic [31:0]         addr;
    logic [31:0]         data;
    logic [RSV_ID_W-1:0] rsv;
    logic                resp;
    logic [31:0]         exp;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [31:0] mem_m [4096];
    logic [INSTR_W-1:0] ops [8];
    logic resp_pend, out_pend, exp_ready, acc;
    logic [CDB_W-1:0] exp_resp;
    logic [7:0] exp_byte;
    logic [31:0] ra;
    logic [11:0] a;
    int x0, g0;

    vt[0] = '{I_STOREB, 32'd5,      32'h12345678, 5'd0,  1'b0, 32'h0};
    vt[1] = '{I_LOADB,  32'd5,      32'h0,        5'd1,  1'b1, 32'h00000078};
    vt[2] = '{I_LOAD,   32'd5,      32'h0,        5'd2,  1'b1, 32'hDEADBE78};
    vt[3] = '{I_STORE,  32'h1005,   32'd7,        5'd0,  1'b0, 32'h0};
    vt[4] = '{I_LOAD,   32'd5,      32'h0,        5'd4,  1'b1, 32'd7};
    vt[5] = '{6'h3F,    32'd5,      32'hFFFFFFFF, 5'd0,  1'b0, 32'h0};
    vt[6] = '{I_LOAD,   32'd5,      32'h0,        5'd5,  1'b1, 32'd7};
    vt[7] = '{I_STORER, 32'hFFF,    32'hCAFEF00D, 5'd0,  1'b0, 32'h0};
    vt[8] = '{I_LOAD,   32'h7FFF,   32'h0,        5'd31, 1'b1, 32'hCAFEF00D};

    rst = 1'b1; clear = 1'b0; i_valid = 1'b0; i_opcode = '0; i_rsv_id = '0;
    i_address = '0; i_data = '0; o_cdb_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdb_valid", 64'(o_cdb_valid), 64'(0));
    chk("rst_cdb", 64'(o_cdb), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    settle();
    chk("rst_release_ready", 64'(i_ready), 64'(1));

    // Store then load, response one cycle after accept
    cyc(); drive(I_STORE, 32'd5, 32'hDEADBEEF, 5'd0); settle();
    chk("store_ready", 64'(i_ready), 64'(1));
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd3); o_cdb_ready = 1'b1; settle();
    chk("load_ready", 64'(i_ready), 64'(1));
    cyc(); i_valid = 1'b0; settle();
    chk("load_cdb_valid", 64'(o_cdb_valid), 64'(1));
    chk("load_cdb", 64'(o_cdb), 64'(cdbv(5'd3, 32'hDEADBEEF)));
    chk("load_busy", 64'(i_ready), 64'(0));
    cyc(); settle();
    chk("load_done_valid", 64'(o_cdb_valid), 64'(0));
    chk("load_done_ready", 64'(i_ready), 64'(1));

    for (int i = 0; i < 9; i++) begin
      cyc(); drive(vt[i].op, vt[i].addr, vt[i].data, vt[i].rsv); o_cdb_ready = 1'b1; settle();
      chk($sformatf("vec%0d_ready", i), 64'(i_ready), 64'(1));
      cyc(); i_valid = 1'b0; settle();
      chk($sformatf("vec%0d_cdb_valid", i), 64'(o_cdb_valid), 64'(vt[i].resp));
      if (vt[i].resp)
        chk($sformatf("vec%0d_cdb", i), 64'(o_cdb), 64'(cdbv(vt[i].rsv, vt[i].exp)));
    end

    // Response held under backpressure for three cycles
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd9); o_cdb_ready = 1'b0; settle();
    x0 = xfers;
    cyc(); i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) o_cdb_ready = 1'b1;
      settle();
      chk($sformatf("stall%0d_valid", k), 64'(o_cdb_valid), 64'(1));
      chk($sformatf("stall%0d_cdb", k), 64'(o_cdb), 64'(cdbv(5'd9, 32'd7)));
      chk($sformatf("stall%0d_busy", k), 64'(i_ready), 64'(0));
      cyc();
    end
    settle();
    chk("stall_after_valid", 64'(o_cdb_valid), 64'(0));
    chk("stall_after_ready", 64'(i_ready), 64'(1));
    chk("stall_one_xfer", 64'(xfers - x0), 64'(1));

    // Output stream backpressure and in-order drain
    g0 = got.size();
    cyc(); out_ready = 1'b0; drive(I_OUTPUT, 32'h0, 32'h41, 5'd0); settle();
    chk("out1_ready", 64'(i_ready), 64'(1));
    cyc(); drive(I_OUTPUT, 32'h0, 32'h42, 5'd0); settle();
    chk("out1_valid", 64'(out_valid), 64'(1));
    chk("out1_data", 64'(out_data), 64'(8'h41));
    chk("out2_stalled", 64'(i_ready), 64'(0));
    cyc(); settle();
    chk("out1_hold", 64'(out_data), 64'(8'h41));
    chk("out2_still_stalled", 64'(i_ready), 64'(0));
    cyc(); out_ready = 1'b1; settle();
    chk("out2_ready_on_drain", 64'(i_ready), 64'(1));
    cyc(); i_valid = 1'b0; settle();
    chk("out2_valid", 64'(out_valid), 64'(1));
    chk("out2_data", 64'(out_data), 64'(8'h42));
    cyc(); settle();
    chk("out_empty", 64'(out_valid), 64'(0));
    chk("out_count", 64'(got.size() - g0), 64'(2));
    chk("out_byte0", 64'((got.size() > g0) ? got[g0] : 8'hEE), 64'(8'h41));
    chk("out_byte1", 64'((got.size() > g0 + 1) ? got[g0+1] : 8'hEE), 64'(8'h42));

    // Clear discards a pending response; RAM keeps its contents
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd2); o_cdb_ready = 1'b0; settle();
    cyc(); i_valid = 1'b0; settle();
    chk("clr_pre_valid", 64'(o_cdb_valid), 64'(1));
    clear = 1'b1; settle();
    chk("clr_ready", 64'(i_ready), 64'(0));
    cyc(); clear = 1'b0; settle();
    chk("clr_valid", 64'(o_cdb_valid), 64'(0));
    chk("clr_cdb", 64'(o_cdb), 64'(0));
    chk("clr_idle_ready", 64'(i_ready), 64'(1));
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd6); o_cdb_ready = 1'b1; settle();
    cyc(); i_valid = 1'b0; settle();
    chk("clr_ram_intact", 64'(o_cdb), 64'(cdbv(5'd6, 32'd7)));
    // clear coinciding with grant still counts as a delivery
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd7); o_cdb_ready = 1'b0; settle();
    cyc(); i_valid = 1'b0; x0 = xfers; clear = 1'b1; o_cdb_ready = 1'b1; settle();
    cyc(); clear = 1'b0; settle();
    chk("clr_grant_valid", 64'(o_cdb_valid), 64'(0));
    chk("clr_grant_xfer", 64'(xfers - x0), 64'(1));

    // Asynchronous reset mid-cycle
    cyc(); out_ready = 1'b0; o_cdb_ready = 1'b0; drive(I_OUTPUT, 32'h0, 32'h5A, 5'd0); settle();
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd12); settle();
    cyc(); i_valid = 1'b0; settle();
    chk("arst_pre_cdb", 64'(o_cdb_valid), 64'(1));
    chk("arst_pre_out", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_cdb_valid", 64'(o_cdb_valid), 64'(0));
    chk("arst_cdb", 64'(o_cdb), 64'(0));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    #1 rst = 1'b0;
    settle();
    chk("arst_ready", 64'(i_ready), 64'(1));
    cyc(); drive(I_LOAD, 32'd5, 32'h0, 5'd1); o_cdb_ready = 1'b1; settle();
    cyc(); i_valid = 1'b0; settle();
    chk("arst_ram_intact", 64'(o_cdb), 64'(cdbv(5'd1, 32'd7)));

    // Randomized run against a transaction-level model
    for (int unsigned w = 16; w < 32; w++) begin
      cyc(); ra = $urandom(); drive(I_STORE, 32'(w), ra, 5'd0); mem_m[w] = ra;
    end
    cyc(); i_valid = 1'b0;
    ops = '{I_LOAD, I_LOADB, I_STORE, I_STOREB, I_STORER, I_OUTPUT, I_OUTPUT, 6'h3F};
    resp_pend = 1'b0; out_pend = 1'b0; exp_resp = '0; exp_byte = '0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      ra = $urandom();
      ra[11:0] = 12'(16 + $urandom_range(0, 15));
      a = ra[11:0];
      drive(ops[$urandom_range(0, 7)], ra, $urandom(), 5'($urandom()));
      i_valid     = ($urandom_range(0, 9) < 7);
      o_cdb_ready = ($urandom_range(0, 9) < 6);
      out_ready   = ($urandom_range(0, 9) < 5);
      clear       = ($urandom_range(0, 19) == 0);
      settle();
      exp_ready = !resp_pend && !clear && !(i_opcode == I_OUTPUT && out_pend && !out_ready);
      chk("rnd_ready", 64'(i_ready), 64'(exp_ready));
      chk("rnd_cdb_valid", 64'(o_cdb_valid), 64'(resp_pend));
      if (resp_pend) chk("rnd_cdb", 64'(o_cdb), 64'(exp_resp));
      chk("rnd_out_valid", 64'(out_valid), 64'(out_pend));
      if (out_pend) chk("rnd_out_data", 64'(out_data), 64'(exp_byte));
      acc = i_valid && exp_ready;
      if (resp_pend && (o_cdb_ready || clear)) resp_pend = 1'b0;
      if (out_pend && out_ready) out_pend = 1'b0;
      if (acc) begin
        if (i_opcode == I_LOAD) begin
          resp_pend = 1'b1; exp_resp = cdbv(i_rsv_id, mem_m[a]);
        end else if (i_opcode == I_LOADB) begin
          resp_pend = 1'b1; exp_resp = cdbv(i_rsv_id, mem_m[a] & 32'hFF);
        end else if (i_opcode == I_STORE || i_opcode == I_STORER) begin
          mem_m[a] = i_data;
        end else if (i_opcode == I_STOREB) begin
          mem_m[a] = (mem_m[a] & 32'hFFFFFF00) | (i_data & 32'hFF);
        end else if (i_opcode == I_OUTPUT) begin
          out_pend = 1'b1; exp_byte = i_data[7:0];
        end
      end
    end
    cyc(); i_valid = 1'b0; clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
